// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM burst arbiter: FSM encoding, direction codes and
// default geometry.
package psram_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWrite = 3'd2,
    StRead  = 3'd3,
    StDone  = 3'd4
  } psram_state_e;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  localparam int unsigned BitWidthDefault = 16;
  localparam int unsigned BurstLenDefault = 32;

endpackage

// File: rtl/psram_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr (wrapping) wins.
module psram_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned PtrW   = 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [PtrW-1:0]   ptr,
  output logic [NumReq-1:0] gnt
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = (32'(ptr) + off) % NumReq;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter that hands whole bursts of the PSRAM controller to one of
// NUM_REQ requesters at a time.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = BitWidthDefault,
  parameter int unsigned BURST_LEN = BurstLenDefault,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic                           ram_clk,
  input  logic                           ram_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [NUM_REQ*32-1:0]          req_addr,
  input  logic [NUM_REQ*2*BIT_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_grant,
  output logic [NUM_REQ-1:0]             req_wr_ack,
  output logic [NUM_REQ-1:0]             req_rd_valid,
  output logic [2*BIT_WIDTH-1:0]         rd_data,
  output logic [NUM_REQ-1:0]             req_done,
  input  logic                           ctrl_idle,
  input  logic                           ram_wr_valid,
  input  logic                           ram_rd_valid,
  input  logic [2*BIT_WIDTH-1:0]         ram_data_out,
  output logic [31:0]                    addr_in,
  output logic                           rw_ctrl,
  output logic                           ram_en,
  output logic [2*BIT_WIDTH-1:0]         ram_data_in
);

  localparam int unsigned DataW = 2 * BIT_WIDTH;
  localparam int unsigned Beats = BURST_LEN / 2;
  localparam int unsigned CntW  = $clog2(Beats) + 1;
  localparam int unsigned PtrW  = $clog2(NUM_REQ);

  psram_state_e        state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, owner_q, pick_idx;
  logic [CntW-1:0]     beat_q;
  logic [NUM_REQ-1:0]  grant_q, rd_valid_q, pick_gnt;
  logic [31:0]         addr_q;
  logic                rw_q;
  logic [DataW-1:0]    rd_data_q;
  logic                beat_step, last_beat;

  psram_rr_pick #(
    .NumReq (NUM_REQ),
    .PtrW   (PtrW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = PtrW'(i);
    end
  end

  // Beats presented outside the matching data state are ignored.
  assign beat_step = (state_q == StWrite && ram_wr_valid) || (state_q == StRead && ram_rd_valid);
  assign last_beat = (beat_q == CntW'(Beats - 1));

  always_ff @(posedge ram_clk or negedge ram_rst) begin
    if (!ram_rst) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (|req_valid) state_d = StIssue;
      StIssue: if (ctrl_idle) state_d = (rw_q == RD) ? StRead : StWrite;
      StWrite,
      StRead:  if (beat_step && last_beat) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ram_clk or negedge ram_rst) begin
    if (!ram_rst) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_q     <= '0;
      grant_q    <= '0;
      addr_q     <= '0;
      rw_q       <= WR;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_valid_q <= '0;
      if (beat_step) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      case (state_q)
        StIdle: begin
          if (|req_valid) begin
            grant_q <= pick_gnt;
            owner_q <= pick_idx;
            addr_q  <= req_addr[32*pick_idx +: 32];
            rw_q    <= req_rw[pick_idx];
          end
        end
        StWrite: if (beat_step && last_beat) grant_q <= '0;
        StRead: begin
          if (beat_step) begin
            rd_data_q  <= ram_data_out;
            rd_valid_q <= grant_q;
            if (last_beat) grant_q <= '0;
          end
        end
        StDone: rr_ptr_q <= (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        StIssue: ;
        default: begin
          beat_q  <= '0;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ram_en      = 1'b0;
    req_wr_ack  = '0;
    req_done    = '0;
    ram_data_in = '0;
    case (state_q)
      StIssue: ram_en = ctrl_idle;
      StWrite: begin
        ram_data_in = req_wdata[DataW*owner_q +: DataW];
        if (ram_wr_valid) req_wr_ack = grant_q;
      end
      StDone:  req_done[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign req_grant    = grant_q;
  assign req_rd_valid = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign addr_in      = addr_q;
  assign rw_ctrl      = rw_q;

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 16: PSRAM word width; the data bus is 2*BIT_WIDTH.
REQ-002 Parameter BURST_LEN, default 32: words per burst; must be even and at least 2; beats per burst = BURST_LEN/2.
REQ-003 Parameter NUM_REQ, default 2: number of requesters; supported range 2..4.
REQ-004 ram_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 ram_rst  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester burst request; level, held until req_done.
REQ-007 req_rw  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  in  NUM_REQ*32  per-requester burst start address; slice i belongs to requester i.
REQ-009 req_wdata  in  NUM_REQ*2*BIT_WIDTH  per-requester write data; slice i belongs to requester i.
REQ-010 req_grant  out  NUM_REQ  one-hot owner of the controller; all zero when no burst is owned.
REQ-011 req_wr_ack  out  NUM_REQ  write beat consumed; the owner presents its next word on the following cycle.
REQ-012 req_rd_valid  out  NUM_REQ  read beat valid on rd_data for the owner.
REQ-013 rd_data  out  2*BIT_WIDTH  registered copy of ram_data_out; shared by all requesters.
REQ-014 req_done  out  NUM_REQ  one-cycle pulse to the owner when its burst completes.
REQ-015 ctrl_idle  in  1  controller idle and ready for a new command.
REQ-016 ram_wr_valid  in  1  controller consumes one write beat this cycle.
REQ-017 ram_rd_valid  in  1  controller presents one read beat on ram_data_out this cycle.
REQ-018 ram_data_out  in  2*BIT_WIDTH  read data from the controller.
REQ-019 addr_in  out  32  registered burst address to the controller.
REQ-020 rw_ctrl  out  1  registered direction to the controller: 1 = write, 0 = read.
REQ-021 ram_en  out  1  single-cycle command strobe to the controller.
REQ-022 ram_data_in  out  2*BIT_WIDTH  owner's req_wdata slice while in WRITE; zero otherwise.

Function
REQ-023 FSM states: IDLE, ISSUE, WRITE, READ, DONE; encoded in 3 bits.
REQ-024 IDLE, any req_valid: round-robin winner chosen, starting the search at pointer rr_ptr.
- Next cycle: req_grant, addr_in and rw_ctrl are loaded from the winner; state moves to ISSUE.
REQ-025 ISSUE: ram_en = 1 for exactly the first cycle in which ctrl_idle = 1.
- State moves to WRITE when rw_ctrl = 1, otherwise to READ.
- ram_en never exceeds one pulse per burst.
REQ-026 WRITE: each ram_wr_valid cycle asserts req_wr_ack[owner] combinationally and increments the beat counter.
REQ-027 READ: each ram_rd_valid cycle registers ram_data_out into rd_data and increments the beat counter.
- req_rd_valid[owner] asserts one cycle later, aligned with rd_data.
REQ-028 Beat counter width: clog2(BURST_LEN/2)+1.
- On the beat where counter = BURST_LEN/2-1, state moves to DONE and the counter clears.
REQ-029 DONE (one cycle):
- req_done[owner] = 1 and req_grant clears.
- rr_ptr = (owner+1) mod NUM_REQ.
- State returns to IDLE.
REQ-030 Deassertion of req_valid by the owner mid-burst is ignored; the burst always completes.
REQ-031 ram_wr_valid or ram_rd_valid outside the matching state: ignored; no ack, counter unchanged.
REQ-032 Simultaneous requests: fairness via rr_ptr; a continuously requesting requester waits at most NUM_REQ-1 bursts.
REQ-033 Minimum gap between bursts: 1 cycle in DONE plus 1 cycle in IDLE.
REQ-034 Undefined state encodings recover to IDLE on the next clock.

Reset
REQ-035 While ram_rst = 0, all of the following hold:
- State = IDLE; rr_ptr = 0; beat counter = 0.
- req_grant, req_wr_ack, req_rd_valid and req_done = 0.
- ram_en = 0; rw_ctrl = 1; addr_in = 0; rd_data = 0; ram_data_in = 0.
REQ-036 Reset asserted mid-burst aborts the burst; no req_done is generated.

Structure
REQ-037 Shared package psram_pkg holds:
- the FSM state constants;
- the direction constants WR = 1 and RD = 0;
- the default BIT_WIDTH and BURST_LEN.
REQ-038 Sub-module psram_rr_pick: combinational round-robin picker (req vector and pointer in, one-hot winner out); the only sub-module.

Verification
REQ-039 Single write: req_valid[0] = 1, req_rw[0] = 1, addr 0x4, ctrl_idle = 1, 16 wr_valid beats.
- Required: one ram_en pulse, addr_in = 0x4, rw_ctrl = 1, 16 req_wr_ack[0], then one req_done[0].
REQ-040 Read: requester 1 reads, 16 rd_valid beats with data 0x01..0x10.
- Required: req_rd_valid[1] × 16 with rd_data 0x01..0x10, each one cycle after its ram_rd_valid.
REQ-041 Contention: both requesters hold req_valid for 4 bursts.
- Required: grants alternate 0,1,0,1; rr_ptr wraps.
REQ-042 ctrl_idle held 0 for 50 cycles in ISSUE.
- Required: ram_en stays 0, then pulses once after ctrl_idle rises.
REQ-043 Mid-burst events: ram_rst pulsed low after beat 5 of a write.
- Required: all outputs return to reset values; no req_done.
- Separately, owner drops req_valid at beat 3: the burst still completes with 16 acks.
REQ-044 Stray ram_rd_valid pulses during WRITE and in IDLE.
- Required: no req_rd_valid; beat count unaffected.
